// File: rtl/hex_display_scheduler.sv
// Time-shares one external hex-to-7-segment decoder across NUM_DIGITS displays.
// Digits are scanned MSD-first into a shadow buffer and then committed in a single edge.
module hex_display_scheduler #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    busy
);

    localparam int         IDX_W   = $clog2(NUM_DIGITS);
    localparam int         CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0] value_q, value_d;
    logic                       blank_q, blank_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       lz_q, lz_d;
    logic [3:0]                 dec_in_q, dec_in_d;
    logic [NUM_DIGITS-1:0][6:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][6:0] committed_q, committed_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       phase_q, phase_d;
    logic [IDX_W-1:0]           idx_next;

    assign idx_next = idx_q - 1'b1;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d     = state_q;
        value_d     = value_q;
        blank_d     = blank_q;
        idx_d       = idx_q;
        lz_d        = lz_q;
        dec_in_d    = dec_in_q;
        shadow_d    = shadow_q;
        committed_d = committed_q;

        case (state_q)
            IDLE: begin
                dec_in_d = 4'h0;
                if (load_valid) begin
                    value_d  = load_value;
                    blank_d  = blank_lz;
                    idx_d    = IDX_W'(NUM_DIGITS - 1);
                    lz_d     = 1'b1;
                    dec_in_d = load_value[4*NUM_DIGITS-1 -: 4];
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // dec_in_q holds the nibble of the digit being scanned this cycle.
                if (blank_q && lz_q && dec_in_q == 4'h0 && idx_q != '0) begin
                    shadow_d[idx_q] = SEG_OFF;
                end else begin
                    shadow_d[idx_q] = dec_out;
                    lz_d            = 1'b0;
                end
                if (idx_q == '0) begin
                    dec_in_d = 4'h0;
                    state_d  = COMMIT;
                end else begin
                    idx_d    = idx_next;
                    dec_in_d = value_q[idx_next];
                end
            end
            COMMIT: begin
                committed_d = shadow_q;
                state_d     = IDLE;
            end
            default: begin
                dec_in_d = 4'h0;
                state_d  = IDLE;
            end
        endcase

        // Blink timebase runs continuously so enabling blink joins the current phase.
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            value_q     <= '0;
            blank_q     <= 1'b0;
            idx_q       <= '0;
            lz_q        <= 1'b0;
            dec_in_q    <= 4'h0;
            shadow_q    <= {NUM_DIGITS{SEG_OFF}};
            committed_q <= {NUM_DIGITS{SEG_OFF}};
            cnt_q       <= '0;
            phase_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of the others.
            state_q     <= state_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            idx_q       <= idx_d;
            lz_q        <= lz_d;
            dec_in_q    <= dec_in_d;
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign dec_in     = dec_in_q;
    assign load_ready = (state_q == IDLE);
    assign busy       = ~load_ready;
    assign HEX        = (blink_en && phase_q) ? {NUM_DIGITS{SEG_OFF}} : committed_q;

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Time-shares one external combinational hex-to-seven-segment decoder across NUM_DIGITS board HEX displays. A requester loads a packed hex value through a valid/ready handshake. The block walks the digits MSD-first through the shared decoder and buffers each pattern in a shadow register. It then commits all digits atomically, with optional leading-zero blanking and whole-display blinking. It sits between the lab's value sources (switches, counters) and the HEX pins.

Parameters:
NUM_DIGITS, 4, number of HEX displays driven (min 2).
BLINK_DIV, 25000000, clock cycles per blink half-period (min 2; benches override to 4).

Ports:
CLOCK_50  in   1              system clock, rising edge
resetn    in   1              asynchronous active-low reset
load_valid in  1              requester has a value to display
load_ready out 1              block can accept a value
load_value in  4*NUM_DIGITS   packed nibbles; digit i = load_value[4i+3:4i], digit 0 = rightmost
blank_lz  in   1              blank leading zeros; sampled on accept
blink_en  in   1              blink the whole display
dec_in    out  4              nibble presented to the shared decoder
dec_out   in   7              decoder result, same cycle, active-low, bit0=a .. bit6=g
HEX       out  7*NUM_DIGITS   HEXi = HEX[7i+6:7i], active-low
busy      out  1              ~load_ready

Behaviour:
- Clock and reset: one clock, CLOCK_50. resetn is asynchronous, active-low.
- Reset state: state=IDLE; committed and shadow registers = 7'h7F per digit (all segments off); dec_in=0; blink counter=0; blink phase=0. Outputs during and after reset: HEX all 7'h7F, load_ready=1.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - load_ready=1, dec_in=0.
  - load_valid=1 → accept in that cycle. Capture load_value and blank_lz, set idx=NUM_DIGITS-1, set lz=1, go to SCAN.
- SCAN (one digit per cycle):
  - load_ready=0.
  - dec_in = captured nibble[idx].
  - If blank_lz_cap && lz && nibble==0 && idx!=0: shadow[idx]=7'h7F, lz stays 1.
  - Otherwise: shadow[idx]=dec_out, lz=0.
  - idx==0 → COMMIT; else idx decrements.
- COMMIT:
  - All committed registers take the shadow values in one edge; go to IDLE.
  - HEX never shows a partially updated value.
- Latency: accept on edge 0. HEX shows the new value after edge NUM_DIGITS+1. load_ready is back to 1 in the cycle after COMMIT. Throughput is one value per NUM_DIGITS+2 cycles.
- Handshake:
  - load_valid while busy is ignored, with no capture and no queueing. The requester holds load_valid until it sees load_ready.
  - load_value changes after accept have no effect on the current scan.
- Digit 0 is never blanked by leading-zero logic. A value of 0 with blank_lz shows a single "0".
- Blink counter: free-running 0..BLINK_DIV-1. The phase register toggles on wrap, regardless of blink_en.
- Blink output: HEX = (blink_en && phase) ? all 7'h7F : committed. This is combinational from registered phase and the blink_en input. Committed contents are unaffected, and deasserting blink_en restores them in the same cycle.
- Reset mid-SCAN or mid-COMMIT aborts immediately. Shadow is discarded, HEX returns to 7'h7F, state=IDLE.
- Illegal state encodings → IDLE on the next edge.

Test Plan:
- Reset then idle: resetn low 3 cycles, high → HEX=all 7'h7F, load_ready=1, busy=0, dec_in=0.
- Basic load: bench decoder model; load 16'h00A5 with blank_lz=1 → dec_in sequence 0,0,A,5 on consecutive cycles; after edge 5: HEX3=7F, HEX2=7F, HEX1=08, HEX0=12; load_ready high again.
- No blanking and zero case: load 16'h0000 with blank_lz=0 → all four digits 40. Load 16'h0000 with blank_lz=1 → HEX3..1=7F, HEX0=40. Load 16'h8008 with blank_lz=1 → 00,40,40,00 (interior zeros shown).
- Busy handshake: hold load_valid with 16'h1234 accepted, then change to 16'hFFFF during SCAN → FFFF not accepted until load_ready=1. First commit shows 1234 (79,24,30,19 for HEX3..0). FFFF follows 6 cycles after the first accept.
- Blink: BLINK_DIV=4, blink_en=1 with 16'h00A5 committed → HEX alternates blank/value every 4 cycles. Deassert blink_en during a blank phase → value visible in the same cycle.
- Reset mid-scan: assert resetn low during cycle 2 of SCAN → HEX=7F immediately, state IDLE. Previous committed value is not restored.
